// File: rtl/msi_bus_mem.sv
// Round-robin bus arbiter and 32 x 16-bit block memory behind the MSI snooping caches.
// Define MSI_BUS_MEM_PATTERN_INIT_EN to reset memory to a per-address pattern instead of zero.
module msi_bus_mem #(
    parameter int NUM_CACHES  = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CACHES-1:0]    req,
    output logic [NUM_CACHES-1:0]    grant,
    input  logic [3*NUM_CACHES-1:0]  op_in,
    input  logic [5*NUM_CACHES-1:0]  addr_in,
    input  logic [16*NUM_CACHES-1:0] data_in,
    input  logic [NUM_CACHES-1:0]    done_in,
    output logic [2:0]               bus_op,
    output logic [4:0]               bus_addr,
    output logic [15:0]              bus_data,
    output logic                     bus_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_MEM  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    localparam logic [2:0] OP_RD    = 3'd1;
    localparam logic [2:0] OP_UPGR  = 3'd2;
    localparam logic [2:0] OP_FLUSH = 3'd3;
    localparam logic [2:0] OP_RDX   = 3'd4;

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    logic [2:0]            state_q, state_d;
    logic [NUM_CACHES-1:0] grant_q, grant_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           bus_data_q, bus_data_d;
    logic                  bus_done_q, bus_done_d;
    logic [15:0]           mem_q [32];

    logic [2:0]            bus_op_s;
    logic [4:0]            bus_addr_s;
    logic [15:0]           m_data_s;
    logic                  m_req_s;
    logic                  snp_found_s;
    logic [15:0]           snp_data_s;
    logic                  pick_found_s;
    logic [1:0]            pick_idx_s;
    logic [2:0]            cand_s;
    logic                  mem_we_s;
    logic [4:0]            mem_waddr_s;
    logic [15:0]           mem_wdata_s;

    // Master-side view: grant is one-hot, so an AND/OR mux selects the master's lanes.
    always_comb begin
        bus_op_s   = 3'd0;
        bus_addr_s = 5'd0;
        m_data_s   = 16'h0000;
        m_req_s    = 1'b0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            bus_op_s   = bus_op_s   | (op_in[3*i +: 3]    & {3{grant_q[i]}});
            bus_addr_s = bus_addr_s | (addr_in[5*i +: 5]  & {5{grant_q[i]}});
            m_data_s   = m_data_s   | (data_in[16*i +: 16] & {16{grant_q[i]}});
            m_req_s    = m_req_s    | (req[i] & grant_q[i]);
        end
    end

    // Lowest-index non-master snooper that is supplying a flushed block.
    always_comb begin
        snp_found_s = 1'b0;
        snp_data_s  = 16'h0000;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (done_in[i] && !grant_q[i]) begin
                snp_found_s = 1'b1;
                snp_data_s  = data_in[16*i +: 16];
            end else begin
                snp_found_s = snp_found_s;
            end
        end
    end

    // Round-robin search starting just after the last granted cache.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = ptr_q;
        cand_s       = 3'd0;
        for (int k = 1; k <= NUM_CACHES; k++) begin
            cand_s = {1'b0, ptr_q} + 3'(k);
            if (cand_s >= 3'(NUM_CACHES)) begin
                cand_s = cand_s - 3'(NUM_CACHES);
            end else begin
                cand_s = cand_s;
            end
            for (int i = 0; i < NUM_CACHES; i++) begin
                if (!pick_found_s && req[i] && (cand_s == 3'(i))) begin
                    pick_found_s = 1'b1;
                    pick_idx_s   = 2'(i);
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Transaction state machine and memory write selection.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        bus_data_d  = 16'h0000;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus_addr_s;
        mem_wdata_s = 16'h0000;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    grant_d = {{(NUM_CACHES-1){1'b0}}, 1'b1} << pick_idx_s;
                    ptr_d   = pick_idx_s;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                case (bus_op_s)
                    OP_RD, OP_RDX: begin
                        cnt_d   = CNT_W'(MEM_LATENCY);
                        state_d = S_MEM;
                    end
                    OP_UPGR: begin
                        state_d = S_DONE;
                    end
                    OP_FLUSH: begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = m_data_s;
                        bus_data_d  = m_data_s;
                        state_d     = S_DONE;
                    end
                    default: begin
                        // No op yet: a dropped request abandons the bus without bus_done.
                        if (!m_req_s) begin
                            grant_d = {NUM_CACHES{1'b0}};
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end
                endcase
            end
            S_MEM: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (snp_found_s) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = snp_data_s;
                    bus_data_d  = snp_data_s;
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_W'(1)) begin
                    bus_data_d = mem_q[bus_addr_s];
                    state_d    = S_DONE;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_DONE: begin
                state_d = S_REL;
            end
            S_REL: begin
                if (!m_req_s) begin
                    grant_d = {NUM_CACHES{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REL;
                end
            end
            default: begin
                grant_d = {NUM_CACHES{1'b0}};
                state_d = S_IDLE;
            end
        endcase
        bus_done_d = (state_d == S_DONE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= {NUM_CACHES{1'b0}};
            ptr_q      <= 2'(NUM_CACHES - 1);
            cnt_q      <= {CNT_W{1'b0}};
            bus_data_q <= 16'h0000;
            bus_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            bus_data_q <= bus_data_d;
            bus_done_q <= bus_done_d;
        end
    end

    // Block memory with reset-time initialisation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 32; a++) begin
`ifdef MSI_BUS_MEM_PATTERN_INIT_EN
                mem_q[a] <= {3'b000, 5'(a), 3'b111, ~5'(a)};
`else
                mem_q[a] <= 16'h0000;
`endif
            end
        end else if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end else begin
            mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
        end
    end

    assign grant    = grant_q;
    assign bus_op   = bus_op_s;
    assign bus_addr = bus_addr_s;
    assign bus_data = bus_data_q;
    assign bus_done = bus_done_q;

endmodule

// File: tb/tb_msi_bus_mem.sv
// Directed bench for msi_bus_mem: a transaction-level model (memory array, round-robin
// pointer, op timing rules) sets per-cycle expectations that one negedge process checks.
module tb_msi_bus_mem;

    localparam int N = 2;
    localparam int L = 2;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_RD    = 3'd1;
    localparam logic [2:0] OP_UPGR  = 3'd2;
    localparam logic [2:0] OP_FLUSH = 3'd3;
    localparam logic [2:0] OP_RDX   = 3'd4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [3*N-1:0]  op_in;
    logic [5*N-1:0]  addr_in;
    logic [16*N-1:0] data_in;
    logic [N-1:0]    done_in;
    logic [2:0]      bus_op;
    logic [4:0]      bus_addr;
    logic [15:0]     bus_data;
    logic            bus_done;

    logic [N-1:0]    exp_grant;
    logic            exp_done;
    logic [15:0]     exp_data;
    logic [2:0]      exp_op;
    logic [4:0]      exp_addr;
    logic            chk_en;
    logic [15:0]     obs_data;
    logic [15:0]     model_mem [32];
    int              rr_ptr;
    int              vectors;
    int              miscompares;

    msi_bus_mem #(.NUM_CACHES(N), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .op_in(op_in), .addr_in(addr_in), .data_in(data_in), .done_in(done_in),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_data(bus_data), .bus_done(bus_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int a);
        logic [4:0] a5;
        a5 = 5'(a);
`ifdef MSI_BUS_MEM_PATTERN_INIT_EN
        return {3'b000, a5, 3'b111, ~a5};
`else
        return 16'h0000 & {11'd0, a5};
`endif
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 32; a++) model_mem[a] = init_word(a);
        rr_ptr = N - 1;
    endtask

    function automatic int rr_pick();
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (rr_ptr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] g;
        g = '0;
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    // Advance one cycle and publish what the outputs must be during it.
    task automatic tick(input logic [N-1:0] g, input logic dn, input logic [15:0] dat);
        @(posedge clk);
        #1;
        exp_grant = g;
        exp_done  = dn;
        exp_data  = dat;
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Per-cycle comparison; bus_op/bus_addr follow the granted cache's lanes.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_op   = 3'd0;
            exp_addr = 5'd0;
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    exp_op   = op_in[3*i +: 3];
                    exp_addr = addr_in[5*i +: 5];
                end
            end
            vectors++;
            if (grant !== exp_grant) begin
                miscompares++;
                $display("FAIL grant got %b want %b t=%0t", grant, exp_grant, $time);
            end
            if (bus_op !== exp_op) begin
                miscompares++;
                $display("FAIL bus_op got %0d want %0d t=%0t", bus_op, exp_op, $time);
            end
            if (bus_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL bus_addr got %0d want %0d t=%0t", bus_addr, exp_addr, $time);
            end
            if (bus_done !== exp_done) begin
                miscompares++;
                $display("FAIL bus_done got %b want %b t=%0t", bus_done, exp_done, $time);
            end
            if (bus_data !== exp_data) begin
                miscompares++;
                $display("FAIL bus_data got %h want %h t=%0t", bus_data, exp_data, $time);
            end
            if (bus_done === 1'b1) obs_data = bus_data;
        end
    end

    // One complete transaction from an idle bus; snp<0 means no snooper flush.
    task automatic do_txn(input int m, input logic [2:0] op, input logic [4:0] a,
                          input logic [15:0] d, input logic mdone, input int snp,
                          input int snp_at, input logic [15:0] sd, input int hold);
        logic [N-1:0] g;
        int           w;
        bit           fin;
        req[m]              = 1'b1;
        op_in[3*m +: 3]     = op;
        addr_in[5*m +: 5]   = a;
        data_in[16*m +: 16] = d;
        done_in[m]          = mdone;
        w = rr_pick();
        if (w >= 0) rr_ptr = w;
        g = onehot(w);
        tick(g, 1'b0, 16'h0000);
        if (op == OP_RD || op == OP_RDX) begin
            tick(g, 1'b0, 16'h0000);
            fin = 1'b0;
            for (int k = 0; k < L && !fin; k++) begin
                if (snp >= 0 && k == snp_at) begin
                    done_in[snp]          = 1'b1;
                    data_in[16*snp +: 16] = sd;
                    model_mem[a]          = sd;
                    tick(g, 1'b1, sd);
                    done_in[snp] = 1'b0;
                    fin = 1'b1;
                end else if (k == L - 1) begin
                    tick(g, 1'b1, model_mem[a]);
                    fin = 1'b1;
                end else begin
                    tick(g, 1'b0, 16'h0000);
                end
            end
        end else if (op == OP_UPGR) begin
            tick(g, 1'b1, 16'h0000);
        end else begin
            model_mem[a] = d;
            tick(g, 1'b1, d);
        end
        done_in[m] = 1'b0;
        tick(g, 1'b0, 16'h0000);
        for (int h = 0; h < hold; h++) tick(g, 1'b0, 16'h0000);
        req[m] = 1'b0;
        tick('0, 1'b0, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        vectors = 0; miscompares = 0; chk_en = 1'b0; obs_data = 16'h0000;
        exp_grant = '0; exp_done = 1'b0; exp_data = 16'h0000;
        reset = 1'b1; req = '0; op_in = '0; addr_in = '0; data_in = '0; done_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick('0, 1'b0, 16'h0000);
        reset = 1'b0;
        tick('0, 1'b0, 16'h0000);

        // Both caches request together: cache0 first, cache1 waits.
        req[1] = 1'b1; op_in[5:3] = OP_RD; addr_in[9:5] = 5'd5;
        req[0] = 1'b1;
        chk16("rr_first_pick", 16'(rr_pick()), 16'd0);
        do_txn(0, OP_RD, 5'd5, 16'h0000, 1'b0, -1, 0, 16'h0000, 1);
`ifdef MSI_BUS_MEM_PATTERN_INIT_EN
        chk16("rd5_init", obs_data, 16'h05FA);
`else
        chk16("rd5_init", obs_data, 16'h0000);
`endif
        do_txn(1, OP_FLUSH, 5'd3, 16'h1234, 1'b1, -1, 0, 16'h0000, 0);
        chk16("flush3_data", obs_data, 16'h1234);

        // Both request again: pointer sits on cache1, so cache0 wins; master done_in ignored.
        req[1] = 1'b1; op_in[5:3] = OP_UPGR; addr_in[9:5] = 5'd7;
        req[0] = 1'b1;
        chk16("rr_second_pick", 16'(rr_pick()), 16'd0);
        do_txn(0, OP_RD, 5'd3, 16'hFFFF, 1'b1, -1, 0, 16'h0000, 0);
        chk16("rd3_after_flush", obs_data, 16'h1234);
        obs_data = 16'hDEAD;
        do_txn(1, OP_UPGR, 5'd7, 16'h0000, 1'b0, -1, 0, 16'h0000, 0);
        chk16("upgr7_data", obs_data, 16'h0000);

        // Snooper flush during the memory wait supplies the block.
        do_txn(0, OP_RDX, 5'd9, 16'h0000, 1'b0, 1, 0, 16'hBEEF, 1);
        chk16("rdx9_snoop", obs_data, 16'hBEEF);
        do_txn(1, OP_RD, 5'd9, 16'h0000, 1'b0, -1, 0, 16'h0000, 0);
        chk16("rd9_after_snoop", obs_data, 16'hBEEF);

        // Snooper flush on the expiry cycle beats the memory read.
        do_txn(0, OP_RD, 5'd5, 16'h0000, 1'b0, 1, L - 1, 16'hA5A5, 0);
        chk16("snoop_at_expiry", obs_data, 16'hA5A5);
        do_txn(1, OP_RD, 5'd7, 16'h0000, 1'b0, -1, 0, 16'h0000, 0);
        chk16("rd7_unchanged", obs_data, init_word(7));

        // Request withdrawn before any op: bus released, no bus_done.
        req[0] = 1'b1; op_in[2:0] = OP_NONE; addr_in[4:0] = 5'd2;
        rr_ptr = rr_pick();
        g = onehot(rr_ptr);
        tick(g, 1'b0, 16'h0000);
        tick(g, 1'b0, 16'h0000);
        req[0] = 1'b0;
        tick('0, 1'b0, 16'h0000);
        tick('0, 1'b0, 16'h0000);

        // Reset while waiting on memory aborts the transaction.
        req[1] = 1'b1; op_in[5:3] = OP_RD; addr_in[9:5] = 5'd5;
        rr_ptr = rr_pick();
        g = onehot(rr_ptr);
        tick(g, 1'b0, 16'h0000);
        tick(g, 1'b0, 16'h0000);
        reset = 1'b1;
        tick('0, 1'b0, 16'h0000);
        model_reset();
        reset = 1'b0; req = '0;
        tick('0, 1'b0, 16'h0000);
        do_txn(0, OP_RD, 5'd9, 16'h0000, 1'b0, -1, 0, 16'h0000, 0);
`ifdef MSI_BUS_MEM_PATTERN_INIT_EN
        chk16("rd9_after_reset", obs_data, 16'h09F6);
`else
        chk16("rd9_after_reset", obs_data, 16'h0000);
`endif
        tick('0, 1'b0, 16'h0000);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
